move_repeater: RTL

//   Turns the debounced level outputs of four direction buttons (up/down/left/right) into a stream of move commands.
//   - Each new press issues one immediate command.
//   - Holding the button issues further commands: first after an initial hold delay, then at a fixed repeat rate.
//   - Commands are buffered in a small FIFO and offered to game logic over a valid/ready handshake.
//   - Sits between the per-button debouncers and the frog movement logic.

---
 rtl/move_repeater.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/move_repeater.sv
// -----------------------------------------------------------------------------
// move_repeater
//   Converts the debounced levels of four direction buttons into a stream of
//   move commands. A new press issues one command immediately. Holding the
//   button issues a first auto-repeat after a hold delay, then further repeats
//   at a fixed rate. Commands are queued in a small first-word-fall-through
//   FIFO and offered to the consumer over a valid/ready handshake.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset, synchronous release
//   btn_level   in   [3:0] debounced levels: 0=up 1=down 2=left 3=right
//   cmd_valid   out  FIFO non-empty, cmd_dir holds the head entry
//   cmd_dir     out  [1:0] head direction
//   cmd_ready   in   consumer takes the head when cmd_valid & cmd_ready
//   fifo_count  out  number of buffered commands
//   drop_tick   out  pulse for the cycle a command is lost to a full FIFO
// -----------------------------------------------------------------------------
module move_repeater #(
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    btn_level,
    output logic                          cmd_valid,
    output logic [1:0]                    cmd_dir,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop_tick
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;
    // One spare bit so the full period (not period-1) can always be loaded.
    localparam int unsigned TMR_W = CNT_W + 1;

    // The timer is loaded with the full period: together with the cycle spent
    // issuing the event this yields a spacing of period+1 between commands.
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYCLES);
    localparam logic [CNT_FW-1:0] FULL_CNT   = CNT_FW'(FIFO_DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StHold   = 2'd1;
    localparam logic [1:0] StRepeat = 2'd2;

    // ------------------------------------------------------------------
    // Edge detect and press arbitration
    // ------------------------------------------------------------------
    logic [3:0] prev_q, prev_d;
    logic [3:0] rise;
    logic [1:0] win_dir;

    always_comb begin
        prev_d = btn_level;
        rise   = btn_level & ~prev_q;
        // Lowest index wins when several buttons rise together.
        if (rise[0]) begin
            win_dir = 2'd0;
        end else if (rise[1]) begin
            win_dir = 2'd1;
        end else if (rise[2]) begin
            win_dir = 2'd2;
        end else begin
            win_dir = 2'd3;
        end
    end

    // ------------------------------------------------------------------
    // Hold / repeat FSM
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [1:0]       trk_q, trk_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ev_vld_q, ev_vld_d;
    logic [1:0]       ev_dir_q, ev_dir_d;

    always_comb begin
        state_d  = state_q;
        trk_d    = trk_q;
        timer_d  = timer_q;
        ev_vld_d = 1'b0;
        ev_dir_d = ev_dir_q;

        if (rise != 4'b0000) begin
            // A new press always preempts, including a re-press of trk.
            trk_d    = win_dir;
            ev_vld_d = 1'b1;
            ev_dir_d = win_dir;
            timer_d  = HOLD_LOAD;
            state_d  = StHold;
        end else if (state_q != StIdle) begin
            if (!btn_level[trk_q]) begin
                state_d = StIdle;
            end else if (timer_q == '0) begin
                ev_vld_d = 1'b1;
                ev_dir_d = trk_q;
                timer_d  = REPEAT_LOAD;
                state_d  = StRepeat;
            end else begin
                timer_d = timer_q - TMR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [1:0]        mem_q [FIFO_DEPTH];
    logic [1:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic              rd_en, wr_en, full;

    always_comb begin
        full      = (count_q == FULL_CNT);
        cmd_valid = (count_q != '0);
        rd_en     = cmd_valid & cmd_ready;
        // A simultaneous read frees the slot the write needs.
        wr_en     = ev_vld_q & (~full | rd_en);
        drop_tick = ev_vld_q & full & ~rd_en;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = ev_dir_q;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_FW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_FW'(1);
        end

        cmd_dir    = mem_q[rd_ptr_q];
        fifo_count = count_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Held-through-reset buttons must be released before they fire.
            prev_q   <= 4'b1111;
            state_q  <= StIdle;
            trk_q    <= 2'd0;
            timer_q  <= '0;
            ev_vld_q <= 1'b0;
            ev_dir_q <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            prev_q   <= prev_d;
            state_q  <= state_d;
            trk_q    <= trk_d;
            timer_q  <= timer_d;
            ev_vld_q <= ev_vld_d;
            ev_dir_q <= ev_dir_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule
